// File: rtl/hdmi_pattern_scheduler.sv
// Frame-synchronous pattern sequencer for the HDMI colour-pattern path.
// Holds the DVI transmitter in reset until lock, blanks during startup, then steps patterns at frame boundaries behind a mute window.
module hdmi_pattern_scheduler #(
  parameter int NUM_PATTERNS       = 4,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int MUTE_FRAMES        = 2,
  parameter int LOCK_FRAMES        = 4,
  localparam int PW = (NUM_PATTERNS > 2) ? $clog2(NUM_PATTERNS) : 1
) (
  input  logic          pixel_clk,
  input  logic          sys_rst_n,
  input  logic          clk_locked,
  input  logic          video_vs,
  input  logic          auto_en,
  input  logic          key_next,
  output logic [PW-1:0] pattern_sel,
  output logic          mute,
  output logic          tx_rst_n,
  output logic [1:0]    state
);

  localparam int MAX_A = (FRAMES_PER_PATTERN > MUTE_FRAMES) ? FRAMES_PER_PATTERN : MUTE_FRAMES;
  localparam int MAX_F = (MAX_A > LOCK_FRAMES) ? MAX_A : LOCK_FRAMES;
  localparam int CW    = $clog2(MAX_F + 1);

  localparam logic [CW-1:0] FPP_LAST  = CW'(FRAMES_PER_PATTERN - 1);
  localparam logic [CW-1:0] MUTE_LAST = CW'(MUTE_FRAMES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_FRAMES - 1);
  localparam logic [PW-1:0] SEL_LAST  = PW'(NUM_PATTERNS - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STARTUP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_MUTE      = 2'd3
  } state_t;

  state_t        state_r, state_nx_s;
  logic          vs_d_r;
  logic          sof_s;
  logic          switch_s;
  logic [CW-1:0] frame_cnt_r, frame_cnt_nx_s;
  logic          key_req_r, key_req_nx_s;
  logic [PW-1:0] pattern_sel_r, pattern_sel_nx_s;
  logic          mute_r, mute_nx_s;
  logic          tx_rst_n_r, tx_rst_n_nx_s;

  assign sof_s = video_vs & ~vs_d_r;

  // Next-state, counter, key request and pattern selection.
  always_comb begin
    state_nx_s       = state_r;
    frame_cnt_nx_s   = frame_cnt_r;
    key_req_nx_s     = key_req_r;
    pattern_sel_nx_s = pattern_sel_r;
    switch_s         = 1'b0;

    // Lock loss overrides everything except the pattern index, which is kept.
    if ((state_r != ST_WAIT_LOCK) && !clk_locked) begin
      state_nx_s     = ST_WAIT_LOCK;
      frame_cnt_nx_s = '0;
      key_req_nx_s   = 1'b0;
    end else begin
      case (state_r)
        ST_WAIT_LOCK: begin
          frame_cnt_nx_s = '0;
          key_req_nx_s   = 1'b0;
          if (clk_locked) begin
            state_nx_s = ST_STARTUP;
          end else begin
            state_nx_s = ST_WAIT_LOCK;
          end
        end
        ST_STARTUP: begin
          key_req_nx_s = key_req_r | key_next;
          if (sof_s) begin
            if (frame_cnt_r == LOCK_LAST) begin
              frame_cnt_nx_s = '0;
              state_nx_s     = ST_RUN;
            end else begin
              frame_cnt_nx_s = frame_cnt_r + CW'(1);
            end
          end else begin
            frame_cnt_nx_s = frame_cnt_r;
          end
        end
        ST_RUN: begin
          switch_s = sof_s & (key_req_r | (auto_en & (frame_cnt_r == FPP_LAST)));
          if (switch_s) begin
            pattern_sel_nx_s = (pattern_sel_r == SEL_LAST) ? '0 : pattern_sel_r + PW'(1);
            key_req_nx_s     = key_next;
            frame_cnt_nx_s   = '0;
            state_nx_s       = ST_MUTE;
          end else if (sof_s) begin
            key_req_nx_s   = key_req_r | key_next;
            frame_cnt_nx_s = (frame_cnt_r == FPP_LAST) ? frame_cnt_r : frame_cnt_r + CW'(1);
          end else begin
            key_req_nx_s = key_req_r | key_next;
          end
        end
        ST_MUTE: begin
          key_req_nx_s = key_req_r | key_next;
          if (sof_s) begin
            if (frame_cnt_r == MUTE_LAST) begin
              frame_cnt_nx_s = '0;
              state_nx_s     = ST_RUN;
            end else begin
              frame_cnt_nx_s = frame_cnt_r + CW'(1);
            end
          end else begin
            frame_cnt_nx_s = frame_cnt_r;
          end
        end
        default: begin
          state_nx_s     = ST_WAIT_LOCK;
          frame_cnt_nx_s = '0;
          key_req_nx_s   = 1'b0;
        end
      endcase
    end

    mute_nx_s     = (state_nx_s != ST_RUN);
    tx_rst_n_nx_s = (state_nx_s != ST_WAIT_LOCK);
  end

  // State, counters and registered outputs.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r       <= ST_WAIT_LOCK;
      vs_d_r        <= 1'b0;
      frame_cnt_r   <= '0;
      key_req_r     <= 1'b0;
      pattern_sel_r <= '0;
      mute_r        <= 1'b1;
      tx_rst_n_r    <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      vs_d_r        <= video_vs;
      frame_cnt_r   <= frame_cnt_nx_s;
      key_req_r     <= key_req_nx_s;
      pattern_sel_r <= pattern_sel_nx_s;
      mute_r        <= mute_nx_s;
      tx_rst_n_r    <= tx_rst_n_nx_s;
    end
  end

  assign pattern_sel = pattern_sel_r;
  assign mute        = mute_r;
  assign tx_rst_n    = tx_rst_n_r;
  assign state       = state_r;

endmodule

// File: tb/tb_hdmi_pattern_scheduler.sv
// Self-checking bench for hdmi_pattern_scheduler: per-frame vector table with a
// scoreboard queue, plus hand sequences for lock, lock loss, held vsync and async reset.
module tb_hdmi_pattern_scheduler;

  logic       pixel_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       clk_locked = 1'b0;
  logic       video_vs = 1'b0;
  logic       auto_en = 1'b0;
  logic       key_next = 1'b0;
  logic [1:0] pattern_sel;
  logic       mute;
  logic       tx_rst_n;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;
  int fnum  = 0;

  typedef struct {
    logic [1:0] sel;
    logic       mute;
    logic [1:0] st;
  } exp_t;

  typedef struct {
    bit         a;
    int         k1;
    int         k2;
    logic [1:0] sel;
    logic       mute;
    logic [1:0] st;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[36];

  hdmi_pattern_scheduler #(
    .NUM_PATTERNS(4),
    .FRAMES_PER_PATTERN(3),
    .MUTE_FRAMES(2),
    .LOCK_FRAMES(2)
  ) dut (
    .pixel_clk(pixel_clk),
    .sys_rst_n(sys_rst_n),
    .clk_locked(clk_locked),
    .video_vs(video_vs),
    .auto_en(auto_en),
    .key_next(key_next),
    .pattern_sel(pattern_sel),
    .mute(mute),
    .tx_rst_n(tx_rst_n),
    .state(state)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s frame=%0d: got %0h expected %0h", name, fnum, act, expv);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".pattern_sel"}, {6'd0, pattern_sel}, {6'd0, e.sel});
    chk({tag, ".mute"}, {7'd0, mute}, {7'd0, e.mute});
    chk({tag, ".tx_rst_n"}, {7'd0, tx_rst_n}, {7'd0, (e.st != 2'd0)});
    chk({tag, ".state"}, {6'd0, state}, {6'd0, e.st});
  endtask

  function automatic exp_t mk(input logic [1:0] s, input logic m, input logic [1:0] st);
    exp_t e;
    e.sel  = s;
    e.mute = m;
    e.st   = st;
    return e;
  endfunction

  // One 100-clock frame: vs high for 5 clocks; expectation pushed at the sof, popped one clock later.
  task automatic frame(input bit a, input int k1, input int k2,
                       input logic [1:0] es, input logic em, input logic [1:0] est);
    exp_t e;
    fnum++;
    for (int i = 0; i < 100; i++) begin
      @(negedge pixel_clk);
      if (i == 1) begin
        if (exp_q.size() == 0) begin
          chk("frame.queue_empty", 8'd1, 8'd0);
        end else begin
          e = exp_q.pop_front();
          chk_all("frame", e);
        end
      end
      if (i == 0) begin
        auto_en = a;
        exp_q.push_back(mk(es, em, est));
      end
      video_vs = (i < 5);
      key_next = (i == k1) || (i == k2);
    end
    key_next = 1'b0;
  endtask

  initial begin
    // {auto_en, key pulse 1, key pulse 2, expected sel, mute, state after this frame's sof}
    tbl = '{
      '{1'b1, -1, -1, 2'd0, 1'b1, 2'd1},  // startup sof 1
      '{1'b1, -1, -1, 2'd0, 1'b0, 2'd2},  // startup sof 2 -> run
      '{1'b1, -1, -1, 2'd0, 1'b0, 2'd2},
      '{1'b1, -1, -1, 2'd0, 1'b0, 2'd2},
      '{1'b1, -1, -1, 2'd1, 1'b1, 2'd3},  // 3rd run sof -> step
      '{1'b1, -1, -1, 2'd1, 1'b1, 2'd3},
      '{1'b1, -1, -1, 2'd1, 1'b0, 2'd2},
      '{1'b1, -1, -1, 2'd1, 1'b0, 2'd2},
      '{1'b1, -1, -1, 2'd1, 1'b0, 2'd2},
      '{1'b1, -1, -1, 2'd2, 1'b1, 2'd3},
      '{1'b1, -1, -1, 2'd2, 1'b1, 2'd3},
      '{1'b1, -1, -1, 2'd2, 1'b0, 2'd2},
      '{1'b1, -1, -1, 2'd2, 1'b0, 2'd2},
      '{1'b1, -1, -1, 2'd2, 1'b0, 2'd2},
      '{1'b1, -1, -1, 2'd3, 1'b1, 2'd3},
      '{1'b1, -1, -1, 2'd3, 1'b1, 2'd3},
      '{1'b1, -1, -1, 2'd3, 1'b0, 2'd2},
      '{1'b1, -1, -1, 2'd3, 1'b0, 2'd2},
      '{1'b1, -1, -1, 2'd3, 1'b0, 2'd2},
      '{1'b1, -1, -1, 2'd0, 1'b1, 2'd3},  // wrap 3 -> 0
      '{1'b1, -1, -1, 2'd0, 1'b1, 2'd3},
      '{1'b1, -1, -1, 2'd0, 1'b0, 2'd2},
      '{1'b0, 20, 40, 2'd0, 1'b0, 2'd2},  // manual: two presses in one frame
      '{1'b0, -1, -1, 2'd1, 1'b1, 2'd3},  // single advance
      '{1'b0, -1, -1, 2'd1, 1'b1, 2'd3},
      '{1'b0, -1, -1, 2'd1, 1'b0, 2'd2},
      '{1'b0, -1, -1, 2'd1, 1'b0, 2'd2},
      '{1'b0, -1, -1, 2'd1, 1'b0, 2'd2},
      '{1'b0, -1, -1, 2'd1, 1'b0, 2'd2},  // count saturated, no change
      '{1'b0, 50, -1, 2'd1, 1'b0, 2'd2},  // press before auto re-enable
      '{1'b1, -1, -1, 2'd2, 1'b1, 2'd3},  // auto + key coincide: one advance
      '{1'b1, -1, -1, 2'd2, 1'b1, 2'd3},
      '{1'b1, -1, -1, 2'd2, 1'b0, 2'd2},
      '{1'b1, -1, -1, 2'd2, 1'b0, 2'd2},  // no leftover key request
      '{1'b1, -1, -1, 2'd2, 1'b0, 2'd2},
      '{1'b1, -1, -1, 2'd3, 1'b1, 2'd3}
    };

    repeat (3) @(negedge pixel_clk);
    chk_all("reset", mk(2'd0, 1'b1, 2'd0));
    sys_rst_n = 1'b1;
    repeat (50) @(negedge pixel_clk);
    chk_all("wait_lock", mk(2'd0, 1'b1, 2'd0));
    clk_locked = 1'b1;
    @(negedge pixel_clk);
    chk_all("lock_edge", mk(2'd0, 1'b1, 2'd1));

    for (int r = 0; r < 36; r++) begin
      frame(tbl[r].a, tbl[r].k1, tbl[r].k2, tbl[r].sel, tbl[r].mute, tbl[r].st);
    end

    // Lock loss during MUTE: one-cycle latency, pattern index retained.
    @(negedge pixel_clk);
    clk_locked = 1'b0;
    @(negedge pixel_clk);
    chk_all("lock_loss", mk(2'd3, 1'b1, 2'd0));
    repeat (10) @(negedge pixel_clk);
    chk_all("lock_lost_hold", mk(2'd3, 1'b1, 2'd0));
    clk_locked = 1'b1;
    @(negedge pixel_clk);
    chk_all("relock", mk(2'd3, 1'b1, 2'd1));
    frame(1'b1, -1, -1, 2'd3, 1'b1, 2'd1);
    frame(1'b1, -1, -1, 2'd3, 1'b0, 2'd2);

    // vsync held high for 300 clocks yields a single sof.
    for (int i = 0; i < 300; i++) begin
      @(negedge pixel_clk);
      video_vs = 1'b1;
    end
    @(negedge pixel_clk);
    video_vs = 1'b0;
    chk_all("vs_held", mk(2'd3, 1'b0, 2'd2));
    frame(1'b1, -1, -1, 2'd3, 1'b0, 2'd2);

    // Asynchronous reset between clock edges.
    @(negedge pixel_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_all("async_reset", mk(2'd0, 1'b1, 2'd0));
    repeat (3) @(negedge pixel_clk);
    chk_all("reset_hold", mk(2'd0, 1'b1, 2'd0));

    if (exp_q.size() != 0) begin
      chk("scoreboard_leftover", 8'(exp_q.size()), 8'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdmi_pattern_scheduler.md
# hdmi_pattern_scheduler

Frame-synchronous sequencer for the HDMI colour-pattern output path, in the pixel_clk domain. It holds the DVI transmitter in reset until the clock generator reports lock, then runs a startup blanking period. After that it steps the display pattern index either automatically every N frames or on a user request. Pattern changes happen only at frame boundaries, behind a short mute window, so the sink never sees a torn frame.

## Interface
- NUM_PATTERNS, 4, number of selectable patterns (≥2); PW = max(1, $clog2(NUM_PATTERNS))
- FRAMES_PER_PATTERN, 120, frames shown per pattern in auto mode (≥1)
- MUTE_FRAMES, 2, frames forced black around each switch (≥1)
- LOCK_FRAMES, 4, black frames after lock before normal output (≥1)
- pixel_clk  in  1  pixel clock; all logic on rising edge; one clock only
- sys_rst_n  in  1  asynchronous, active-low reset
- clk_locked  in  1  clock-generator lock, synchronous to pixel_clk
- video_vs  in  1  vertical sync from the video driver, active-high
- auto_en  in  1  level; 1 = advance every FRAMES_PER_PATTERN frames
- key_next  in  1  single-cycle debounced request to advance one pattern
- pattern_sel  out  PW  pattern index to the display generator
- mute  out  1  1 = display generator must output black (24'h000000)
- tx_rst_n  out  1  active-low reset for the DVI transmitter
- state  out  2  0 WAIT_LOCK, 1 STARTUP, 2 RUN, 3 MUTE

## Operation
- Frame start (sof): video_vs registered to vs_d; sof = video_vs & ~vs_d, evaluated in the same cycle.
- Counters: frame_cnt of width $clog2(max(FRAMES_PER_PATTERN, MUTE_FRAMES, LOCK_FRAMES)+1).
- key_req flag:
  - key_next sets it in STARTUP, RUN and MUTE; in WAIT_LOCK key_next is ignored.
  - It is cleared when a switch is taken.
  - Multiple presses before a switch coalesce into one advance.
- FSM:
  - WAIT_LOCK: tx_rst_n=0, mute=1, frame_cnt=0, key_req=0. When clk_locked=1, go to STARTUP.
  - STARTUP: tx_rst_n=1, mute=1. Each sof increments frame_cnt. At the sof where frame_cnt == LOCK_FRAMES-1, clear frame_cnt and go to RUN.
  - RUN: mute=0. Each sof evaluates switch = key_req | (auto_en & frame_cnt == FRAMES_PER_PATTERN-1).
    - If switch: pattern_sel advances (NUM_PATTERNS-1 wraps to 0), key_req clears, frame_cnt=0, go to MUTE.
    - Otherwise: frame_cnt increments, saturating at FRAMES_PER_PATTERN-1.
  - MUTE: mute=1. Each sof increments frame_cnt. At the sof where frame_cnt == MUTE_FRAMES-1, clear frame_cnt and go to RUN.
- clk_locked=0 in any state other than WAIT_LOCK: go to WAIT_LOCK next edge and clear counters and key_req. pattern_sel is retained.
- Auto switch and key_req coinciding on one sof: exactly one advance.
- auto_en=0: frame_cnt holds at saturation. Re-enabling auto with a saturated count switches at the next sof.

## Timing
- All outputs are registered and change only on a pixel_clk edge.
- Reset values: pattern_sel=0, mute=1, tx_rst_n=0, state=0. Also vs_d=0, key_req=0, frame_cnt=0.
- Latency:
  - First video_vs=1 cycle at edge k → sof at k; outputs reflect the transition after edge k+1 (one-cycle latency).
  - clk_locked change → state/tx_rst_n update one cycle later.
- The pattern_sel change and the mute assertion happen on the same edge; pattern_sel is never seen unmuted mid-frame.
- Mute window = MUTE_FRAMES full frames, sof to sof.
- Asynchronous reset mid-operation: all outputs return to reset values immediately, independent of pixel_clk.
- video_vs held high continuously: produces one sof only.

## Test plan
Bench parameters for all scenarios: NUM_PATTERNS=4, FRAMES_PER_PATTERN=3, MUTE_FRAMES=2, LOCK_FRAMES=2. Frame period 100 clocks, vs high 5 clocks.
- Power-up: release sys_rst_n with clk_locked=0 for 50 cycles, then 1.
  - → tx_rst_n=0 and mute=1 until one cycle after lock.
  - → 2 sofs in STARTUP, then mute=0 one cycle after the 2nd sof; pattern_sel=0.
- Auto cycling, auto_en=1:
  - → pattern_sel steps 0→1→2→3→0, each step at every 3rd RUN sof.
  - → mute=1 for exactly 2 frames after each step.
- Manual, auto_en=0:
  - key_next pulsed twice within one frame → single advance at next sof, pattern_sel 0→1, mute for 2 frames.
  - Without further presses → no further change.
- Coincidence: key_next pulsed in the frame where the auto count expires → one advance only (1→2, not 1→3).
- Lock loss: drop clk_locked during MUTE → next cycle state=0, tx_rst_n=0, mute=1, pattern_sel unchanged. Relock → STARTUP repeats.
- Asynchronous reset: assert sys_rst_n=0 mid-frame between clock edges → all outputs at reset values before the next pixel_clk edge.
